// File: rtl/semaforo_pedestre_pkg.sv
// Shared encodings and defaults for the vehicle and pedestrian light controllers.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
package semaforo_pedestre_pkg;

    // Pedestrian FSM states; encodings are shared with the vehicle controller.
    typedef enum logic [1:0] {
        PARADO   = 2'b00,
        ANDANDO  = 2'b01,
        PISCANDO = 2'b10,
        FALHA    = 2'b11
    } estado_t;

    // Vehicle lights packed as {verde, amarela, vermelha}; exactly one lamp lit.
    typedef enum logic [2:0] {
        LUZ_VERDE    = 3'b100,
        LUZ_AMARELA  = 3'b010,
        LUZ_VERMELHA = 3'b001
    } luz_t;

    localparam int TEMPO_ANDAR_PADRAO = 20;
    localparam int MEIO_PISCA_PADRAO  = 2;

    // Walk/flash counter is 5 bits and saturates rather than wrapping.
    localparam logic [4:0] CONT_MAX = 5'd31;

    // A light combination is trustworthy only when exactly one lamp is on.
    function automatic logic luz_valida(input logic [2:0] luzes);
        logic ok;
        case (luzes)
            LUZ_VERDE, LUZ_AMARELA, LUZ_VERMELHA: ok = 1'b1;
            default:                              ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/semaforo_pedestre_sincroniza_borda.sv
// Brings the raw push-button into clk and emits one pulse per press.
// Latency: pulse is registered, 3 rising edges after the input goes high.
// Backpressure: none; holding the button longer never produces a second pulse.
module sincroniza_borda (
    input  logic clk,
    input  logic reset,
    input  logic i_assinc,
    output logic o_pulso
);

    logic r_sinc1;
    logic r_sinc2;
    logic r_ant;
    logic r_pulso;

    // Two-flop synchronizer, previous-value flop and registered rising-edge pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sinc1 <= 1'b0;
            r_sinc2 <= 1'b0;
            r_ant   <= 1'b0;
            r_pulso <= 1'b0;
        end else begin
            r_sinc1 <= i_assinc;
            r_sinc2 <= r_sinc1;
            r_ant   <= r_sinc2;
            r_pulso <= r_sinc2 & ~r_ant;
        end
    end

    assign o_pulso = r_pulso;

endmodule

// File: rtl/semaforo_pedestre.sv
// Pedestrian crossing controller: request latch, walk timer, flashing don't-walk, fault lock-out.
// Latency: lamps and request outputs are registered, 1 cycle after the sampled condition.
// Backpressure: none; the vehicle controller sees pedestre and may serve it at any time.
module semaforo_pedestre
    import semaforo_pedestre_pkg::*;
#(
    parameter int TEMPO_ANDAR = TEMPO_ANDAR_PADRAO,
    parameter int MEIO_PISCA  = MEIO_PISCA_PADRAO
) (
    input  logic clk,
    input  logic reset,
    input  logic botao,
    input  logic luzVerde,
    input  logic luzAmarela,
    input  logic luzVermelha,
    output logic pedestre,
    output logic andar,
    output logic parar,
    output logic pedidoPendente
);

    localparam int MEIO_W = (MEIO_PISCA > 1) ? $clog2(MEIO_PISCA) : 1;

    logic [2:0]        w_luzes;
    logic              w_valida;
    logic              w_pulso;
    logic              w_muda;
    logic              w_entra_andando;
    estado_t           r_estado;
    estado_t           w_prox;
    logic [4:0]        r_cont;
    logic [4:0]        w_cont_prox;
    logic [MEIO_W-1:0] r_meio;
    logic [MEIO_W-1:0] w_meio_prox;
    logic              r_andar;
    logic              w_andar_prox;
    logic              r_parar;
    logic              w_parar_prox;
    logic              r_pedido;
    logic              w_pedido_prox;

    assign w_luzes  = {luzVerde, luzAmarela, luzVermelha};
    assign w_valida = luz_valida(w_luzes);

    sincroniza_borda u_sincroniza_borda (
        .clk      (clk),
        .reset    (reset),
        .i_assinc (botao),
        .o_pulso  (w_pulso)
    );

    // Next state: invalid lights always win; leaving red ends the walk before the timer does.
    always_comb begin
        w_prox = r_estado;
        if (!w_valida) begin
            w_prox = FALHA;
        end else begin
            case (r_estado)
                PARADO: begin
                    if (w_luzes == LUZ_VERMELHA) w_prox = ANDANDO;
                end
                ANDANDO: begin
                    if (!luzVermelha)                             w_prox = PARADO;
                    else if (r_cont == 5'(TEMPO_ANDAR - 1))       w_prox = PISCANDO;
                end
                PISCANDO: begin
                    if (!luzVermelha) w_prox = PARADO;
                end
                FALHA: begin
                    if (w_luzes == LUZ_VERDE) w_prox = PARADO;
                end
                default: w_prox = FALHA;
            endcase
        end
    end

    assign w_muda          = (w_prox != r_estado);
    assign w_entra_andando = w_muda && (w_prox == ANDANDO);

    // Next lamp values, counter, blink phase and request latch, all decoded from the next state.
    always_comb begin
        w_andar_prox  = 1'b0;
        w_parar_prox  = 1'b1;
        w_meio_prox   = '0;
        w_cont_prox   = r_cont;
        w_pedido_prox = r_pedido;

        case (w_prox)
            ANDANDO: begin
                w_andar_prox = 1'b1;
                w_parar_prox = 1'b0;
            end
            PISCANDO: begin
                // Flash begins dark on entry, then flips every MEIO_PISCA cycles.
                if (r_estado != PISCANDO) begin
                    w_parar_prox = 1'b0;
                    w_meio_prox  = '0;
                end else if (r_meio == MEIO_W'(MEIO_PISCA - 1)) begin
                    w_parar_prox = ~r_parar;
                    w_meio_prox  = '0;
                end else begin
                    w_parar_prox = r_parar;
                    w_meio_prox  = r_meio + MEIO_W'(1);
                end
            end
            default: begin
                w_andar_prox = 1'b0;
                w_parar_prox = 1'b1;
            end
        endcase

        if (w_muda) begin
            w_cont_prox = 5'd0;
        end else if ((r_estado == ANDANDO || r_estado == PISCANDO) && r_cont != CONT_MAX) begin
            w_cont_prox = r_cont + 5'd1;
        end

        // Press is only accepted while a request could still be served; walk entry clears it last.
        if (w_pulso && (r_estado == PARADO || r_estado == PISCANDO)) begin
            w_pedido_prox = 1'b1;
        end
        if (w_entra_andando) begin
            w_pedido_prox = 1'b0;
        end
    end

    // State, counter and registered outputs; reset is the safe don't-walk condition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado <= PARADO;
            r_cont   <= 5'd0;
            r_meio   <= '0;
            r_andar  <= 1'b0;
            r_parar  <= 1'b1;
            r_pedido <= 1'b0;
        end else begin
            r_estado <= w_prox;
            r_cont   <= w_cont_prox;
            r_meio   <= w_meio_prox;
            r_andar  <= w_andar_prox;
            r_parar  <= w_parar_prox;
            r_pedido <= w_pedido_prox;
        end
    end

    assign andar          = r_andar;
    assign parar          = r_parar;
    assign pedestre       = r_pedido;
    assign pedidoPendente = r_pedido;

endmodule

// File: tb/tb_semaforo_pedestre.sv
// Directed bench for the pedestrian controller: vector table plus multi-cycle sequences.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_semaforo_pedestre;

    logic clk;
    logic reset;
    logic botao;
    logic luzVerde;
    logic luzAmarela;
    logic luzVermelha;
    logic pedestre;
    logic andar;
    logic parar;
    logic pedidoPendente;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic  b;
        logic  vd;
        logic  am;
        logic  vm;
        logic  e_andar;
        logic  e_parar;
        logic  e_ped;
        string nome;
    } vet_t;

    vet_t tab[$];

    semaforo_pedestre #(
        .TEMPO_ANDAR (20),
        .MEIO_PISCA  (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .botao          (botao),
        .luzVerde       (luzVerde),
        .luzAmarela     (luzAmarela),
        .luzVermelha    (luzVermelha),
        .pedestre       (pedestre),
        .andar          (andar),
        .parar          (parar),
        .pedidoPendente (pedidoPendente)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vet_t v(input logic b, vd, am, vm, ea, ep, eped, input string nome);
        vet_t r;
        r.b = b; r.vd = vd; r.am = am; r.vm = vm;
        r.e_andar = ea; r.e_parar = ep; r.e_ped = eped; r.nome = nome;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic luzes(input logic vd, am, vm);
        luzVerde = vd; luzAmarela = am; luzVermelha = vm;
    endtask

    task automatic chk(input string nome, input logic ea, ep, eped);
        checks++;
        if (andar !== ea || parar !== ep || pedestre !== eped || pedidoPendente !== eped) begin
            errors++;
            $display("FAIL %s: got andar=%0b parar=%0b pedestre=%0b pend=%0b, want andar=%0b parar=%0b pedestre=%0b",
                     nome, andar, parar, pedestre, pedidoPendente, ea, ep, eped);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Table: press while green, walk entry clearing it, presses ignored in walk and fault.
        tab.push_back(v(1,1,0,0, 0,1,0, "press_e1"));
        tab.push_back(v(1,1,0,0, 0,1,0, "press_e2"));
        tab.push_back(v(1,1,0,0, 0,1,0, "press_e3"));
        tab.push_back(v(1,1,0,0, 0,1,1, "press_e4"));
        tab.push_back(v(1,1,0,0, 0,1,1, "press_e5"));
        tab.push_back(v(0,1,0,0, 0,1,1, "held_1"));
        tab.push_back(v(0,1,0,0, 0,1,1, "held_2"));
        tab.push_back(v(0,1,0,0, 0,1,1, "held_3"));
        tab.push_back(v(0,0,1,0, 0,1,1, "yellow_keeps_req"));
        tab.push_back(v(0,0,0,1, 1,0,0, "walk_entry_clears"));
        tab.push_back(v(1,0,0,1, 1,0,0, "walk_press_1"));
        tab.push_back(v(1,0,0,1, 1,0,0, "walk_press_2"));
        tab.push_back(v(0,0,0,1, 1,0,0, "walk_press_3"));
        tab.push_back(v(0,0,0,1, 1,0,0, "walk_press_ign"));
        tab.push_back(v(0,0,0,1, 1,0,0, "walk_press_ign2"));
        tab.push_back(v(0,1,0,0, 0,1,0, "walk_abort_green"));
        tab.push_back(v(0,1,0,1, 0,1,0, "fault_enter"));
        tab.push_back(v(0,0,0,1, 0,1,0, "fault_hold_red1"));
        tab.push_back(v(0,0,0,1, 0,1,0, "fault_hold_red2"));
        tab.push_back(v(1,0,0,1, 0,1,0, "fault_press_1"));
        tab.push_back(v(0,0,0,1, 0,1,0, "fault_press_2"));
        tab.push_back(v(0,0,0,1, 0,1,0, "fault_press_3"));
        tab.push_back(v(0,0,0,1, 0,1,0, "fault_press_ign"));
        tab.push_back(v(0,0,0,1, 0,1,0, "fault_press_ign2"));
        tab.push_back(v(0,1,0,0, 0,1,0, "fault_exit_green"));
        tab.push_back(v(0,0,0,1, 1,0,0, "walk_after_fault"));
        tab.push_back(v(0,0,0,0, 0,1,0, "no_lights_fault"));
        tab.push_back(v(0,1,0,0, 0,1,0, "fault_exit_2"));

        botao = 1'b0;
        luzes(1, 0, 0);
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk("reset_async", 0, 1, 0);
        tick();
        tick();
        chk("reset_held", 0, 1, 0);
        reset = 1'b0;

        for (int i = 0; i < tab.size(); i++) begin
            botao = tab[i].b;
            luzes(tab[i].vd, tab[i].am, tab[i].vm);
            tick();
            chk(tab[i].nome, tab[i].e_andar, tab[i].e_parar, tab[i].e_ped);
        end

        // Full walk: 20 cycles walk, 10 cycles flash with period 4; press during flash latches.
        luzes(0, 0, 1);
        for (int k = 1; k <= 30; k++) begin
            botao = (k == 22 || k == 23);
            tick();
            chk($sformatf("full_walk_k%0d", k),
                (k <= 20),
                (k <= 20) ? 1'b0 : 1'(((k - 21) / 2) % 2),
                (k >= 25));
        end
        botao = 1'b0;
        luzes(1, 0, 0);
        tick();
        chk("walk_end_steady", 0, 1, 1);
        tick();
        chk("walk_end_pending", 0, 1, 1);

        // Early end at walk cycle 7: don't-walk straight away, flash skipped.
        luzes(0, 0, 1);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("early_walk_k%0d", k), 1, 0, 0);
        end
        luzes(1, 0, 0);
        tick();
        chk("early_end", 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("early_no_flash_%0d", k), 0, 1, 0);
        end

        // Edge pulse coincides with walk entry: clear must win.
        botao = 1'b1;
        tick();
        chk("coll_p1", 0, 1, 0);
        tick();
        chk("coll_p2", 0, 1, 0);
        botao = 1'b0;
        tick();
        chk("coll_p3", 0, 1, 0);
        luzes(0, 0, 1);
        tick();
        chk("coll_entry", 1, 0, 0);
        tick();
        chk("coll_after", 1, 0, 0);
        luzes(1, 0, 0);
        tick();
        chk("coll_back_parado", 0, 1, 0);
        tick();
        chk("coll_no_req", 0, 1, 0);

        // Asynchronous reset in the middle of a walk.
        luzes(0, 0, 1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("rst_walk_k%0d", k), 1, 0, 0);
        end
        #3 reset = 1'b1;
        #1;
        chk("reset_mid_walk", 0, 1, 0);
        tick();
        tick();
        chk("reset_hold_red", 0, 1, 0);
        reset = 1'b0;
        tick();
        chk("resume_walk", 1, 0, 0);

        // Reset discards a pending request.
        luzes(1, 0, 0);
        tick();
        chk("pend_parado", 0, 1, 0);
        botao = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("pend_set", 0, 1, 1);
        botao = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("reset_drops_req", 0, 1, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("after_reset_idle", 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/semaforo_pedestre.md
SEMAFORO_PEDESTRE -- requirements
Module: semaforo_pedestre

Interface
REQ-001 Parameter TEMPO_ANDAR, default 20: walk-phase length in clock cycles.
REQ-002 Parameter MEIO_PISCA, default 2: cycles per half-period of the flashing don't-walk signal.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 botao  input  1  raw pedestrian push-button; asynchronous to clk.
REQ-006 luzVerde, luzAmarela, luzVermelha  input  1 each  vehicle lights from the vehicle controller; synchronous to clk.
REQ-007 pedestre  output  1  registered crossing request to the vehicle controller.
REQ-008 andar  output  1  registered walk lamp.
REQ-009 parar  output  1  registered don't-walk lamp; steady or flashing.
REQ-010 pedidoPendente  output  1  registered "request accepted" indicator; equals pedestre.

Function
REQ-011 botao SHALL pass through a 2-flop synchronizer followed by a rising-edge detector; one press yields exactly one edge pulse however long it is held.
REQ-012 The FSM SHALL have 4 states: PARADO (andar=0, parar=1), ANDANDO (andar=1, parar=0), PISCANDO (andar=0, parar toggles), FALHA (andar=0, parar=1).
REQ-013 Light inputs are valid only when exactly one is high; any other combination is invalid.
REQ-014 PARADO -> ANDANDO when luzVermelha alone is sampled high; the cycle counter clears on entry.
REQ-015 ANDANDO -> PISCANDO when the counter reaches TEMPO_ANDAR-1.
REQ-016 ANDANDO or PISCANDO -> PARADO when luzVermelha is sampled low and the lights are valid. This transition is a safety rule and takes priority over REQ-015.
REQ-017 Any state -> FALHA on invalid lights. FALHA -> PARADO only when luzVerde alone is sampled high.
REQ-018 The 5-bit counter SHALL increment every cycle in ANDANDO and PISCANDO, saturate at 31, and clear on every state change.
REQ-019 In PISCANDO, parar SHALL start at 0 and toggle every MEIO_PISCA cycles.
REQ-020 Output latency: lamp outputs SHALL change on the clock edge after the input condition is sampled (1 cycle).
REQ-021 A request latch SHALL be set by an edge pulse in PARADO or PISCANDO, and the pulse SHALL be ignored in ANDANDO and FALHA.
REQ-022 The request latch SHALL clear on entry to ANDANDO. If set and clear occur in the same cycle, clear wins.
REQ-023 pedestre SHALL be high one cycle after the edge pulse and stay high until cleared, regardless of the vehicle light colour.
REQ-024 andar and parar SHALL never be high simultaneously; andar SHALL never be high unless luzVermelha was high in the previous cycle.

Reset
REQ-025 Reset SHALL asynchronously force state PARADO, counter 0, request latch 0, synchronizer and edge flops 0, pedestre=0, pedidoPendente=0, andar=0, parar=1.
REQ-026 Reset asserted mid-walk SHALL drop andar immediately and discard any pending request. After release, operation resumes from PARADO.

Structure
REQ-027 The following SHALL live in a shared package used by both light controllers: state encodings (PARADO=2'b00, ANDANDO=2'b01, PISCANDO=2'b10, FALHA=2'b11), vehicle-light encodings, and default TEMPO_ANDAR/MEIO_PISCA constants.
REQ-028 Synchronizer plus edge detector SHALL be one sub-module, sincroniza_borda. The FSM, counter, blinker and request latch SHALL remain in semaforo_pedestre.

Verification
REQ-029 Single press: botao high 5 cycles while luzVerde=1 -> pedestre rises 4 cycles after the press and stays high. No second request is issued.
REQ-030 Full walk: luzVermelha alone for 30 cycles -> andar=1 for 20 cycles, then parar toggles with period 4 for 10 cycles. parar=1 steady one cycle after luzVermelha falls and luzVerde rises.
REQ-031 Early end: luzVermelha drops at walk cycle 7 -> andar=0 and parar=1 on the next edge, with PISCANDO skipped.
REQ-032 Fault: luzVerde and luzVermelha both high -> FALHA, parar=1. The state stays in FALHA through subsequent valid red. It exits to PARADO only once luzVerde alone is seen.
REQ-033 Clear/set collision: edge pulse on the same cycle as ANDANDO entry -> pedestre=0 afterward. A press during PISCANDO -> pedestre=1 until the next ANDANDO entry.
REQ-034 Async reset asserted at walk cycle 10, between clock edges -> andar=0, parar=1, pedestre=0 without waiting for clk.
